// File: rtl/dec2to4_scan_seq.sv
// Scan sequencer for a 2-to-4 decoder: blanks, then enables each masked channel for dwell+1 cycles.
// Optional build macro SCAN_ONESHOT_EN: stop after a single sweep instead of scanning continuously.
module dec2to4_scan_seq #(
  parameter int DWELL_W   = 8,
  parameter int BLANK_CYC = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [3:0]         ch_mask,
  output logic               en_n,
  output logic               a,
  output logic               b,
  output logic               busy,
  output logic               wrap
);

  typedef enum logic [1:0] {IDLE, BLANK, DWELL} state_t;

  localparam int BW       = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam int BLANK_LD = (BLANK_CYC > 0) ? BLANK_CYC - 1 : 0;

  state_t             state, state_nx;
  logic [1:0]         sel, sel_nx;
  logic               en_n_nx, busy_nx, wrap_nx;
  logic [DWELL_W-1:0] dcnt, dcnt_nx;
  logic [BW-1:0]      bcnt, bcnt_nx;
  logic [2:0]         adv;
  logic               enter;

  function automatic logic [1:0] lowest(input logic [3:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  // Returns {wrapped, channel}: next set bit above cur, searching upward and wrapping 3->0.
  function automatic logic [2:0] next_ch(input logic [1:0] cur, input logic [3:0] m);
    logic [2:0] s, r;
    r = {1'b1, cur};
    for (int k = 4; k >= 1; k--) begin
      s = {1'b0, cur} + 3'(k);
      if (m[s[1:0]]) r = s;
    end
    return r;
  endfunction

  always_comb begin
    state_nx = state;
    sel_nx   = sel;
    wrap_nx  = 1'b0;
    dcnt_nx  = dcnt;
    bcnt_nx  = bcnt;
    enter    = 1'b0;
    adv      = next_ch(sel, ch_mask);

    if (stop) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start && (ch_mask != 4'd0)) begin
            enter  = 1'b1;
            sel_nx = lowest(ch_mask);
          end
        end
        BLANK: begin
          if (bcnt == '0) begin
            state_nx = DWELL;
            dcnt_nx  = dwell;
          end else begin
            bcnt_nx = bcnt - 1'b1;
          end
        end
        DWELL: begin
          if (dcnt != '0) begin
            dcnt_nx = dcnt - 1'b1;
          end else if (ch_mask == 4'd0) begin
            state_nx = IDLE;
          end else begin
`ifdef SCAN_ONESHOT_EN
            if (adv[2]) begin
              state_nx = IDLE;
              wrap_nx  = 1'b1;
            end else begin
              enter  = 1'b1;
              sel_nx = adv[1:0];
            end
`else
            enter   = 1'b1;
            sel_nx  = adv[1:0];
            wrap_nx = adv[2];
`endif
          end
        end
        default: state_nx = IDLE;
      endcase
    end

    // Channel entry: with no blanking the decoder enables on the same edge the address moves.
    if (enter) begin
      if (BLANK_CYC == 0) begin
        state_nx = DWELL;
        dcnt_nx  = dwell;
      end else begin
        state_nx = BLANK;
        bcnt_nx  = BW'(BLANK_LD);
      end
    end

    en_n_nx = (state_nx != DWELL);
    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel   <= 2'd0;
      en_n  <= 1'b1;
      busy  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      state <= state_nx;
      sel   <= sel_nx;
      en_n  <= en_n_nx;
      busy  <= busy_nx;
      wrap  <= wrap_nx;
    end
  end

  // Counters are only read after being loaded on channel entry, so they carry no reset.
  always_ff @(posedge clk) begin
    dcnt <= dcnt_nx;
    bcnt <= bcnt_nx;
  end

  assign a = sel[1];
  assign b = sel[0];

endmodule

// File: tb/tb_dec2to4_scan_seq.sv
// Scoreboard bench for dec2to4_scan_seq: a behavioural model queues expected outputs per edge.
module tb_dec2to4_scan_seq;

  localparam int DWELL_W   = 8;
  localparam int BLANK_CYC = 1;

  logic               clk = 1'b0;
  logic               rst, start, stop;
  logic [DWELL_W-1:0] dwell;
  logic [3:0]         ch_mask;
  logic               en_n, a, b, busy, wrap;

  dec2to4_scan_seq #(.DWELL_W(DWELL_W), .BLANK_CYC(BLANK_CYC)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .dwell(dwell),
    .ch_mask(ch_mask), .en_n(en_n), .a(a), .b(b), .busy(busy), .wrap(wrap)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [4:0] exp_q[$];
  logic       prev_en = 1'b1;
  logic [1:0] prev_ab = 2'd0;

  // model state: 0 idle, 1 blank, 2 dwell
  int   m_st = 0, m_ch = 0, m_left = 0;
  logic m_en = 1'b1, m_busy = 1'b0, m_wrap = 1'b0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic void m_enter();
    if (BLANK_CYC > 0) begin
      m_st   = 1;
      m_left = BLANK_CYC;
    end else begin
      m_st   = 2;
      m_left = int'(dwell) + 1;
    end
  endfunction

  function automatic void m_step();
    int  c;
    bit  found, wrapped;
    if (rst) begin
      m_st = 0; m_ch = 0; m_en = 1'b1; m_busy = 1'b0; m_wrap = 1'b0;
      return;
    end
    m_wrap = 1'b0;
    if (stop) begin
      m_st = 0;
    end else if (m_st == 0) begin
      if (start && ch_mask != 4'd0) begin
        for (int i = 3; i >= 0; i--) if (ch_mask[i]) m_ch = i;
        m_enter();
      end
    end else if (m_st == 1) begin
      m_left--;
      if (m_left == 0) begin
        m_st   = 2;
        m_left = int'(dwell) + 1;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        if (ch_mask == 4'd0) begin
          m_st = 0;
        end else begin
          found = 0; wrapped = 0; c = m_ch;
          for (int i = 1; i <= 4; i++) begin
            if (!found && ch_mask[(m_ch + i) % 4]) begin
              found   = 1;
              c       = (m_ch + i) % 4;
              wrapped = (m_ch + i) >= 4;
            end
          end
`ifdef SCAN_ONESHOT_EN
          if (wrapped) begin
            m_st   = 0;
            m_wrap = 1'b1;
          end else begin
            m_ch = c;
            m_enter();
          end
`else
          m_ch   = c;
          m_wrap = wrapped;
          m_enter();
`endif
        end
      end
    end
    m_en   = (m_st != 2);
    m_busy = (m_st != 0);
  endfunction

  task automatic cycle();
    logic [4:0] e, got;
    m_step();
    exp_q.push_back({m_en, m_ch[1], m_ch[0], m_busy, m_wrap});
    @(posedge clk);
    #1;
    e   = exp_q.pop_front();
    got = {en_n, a, b, busy, wrap};
    check($sformatf("out@%0d", cyc), {3'd0, got}, {3'd0, e});
    if (prev_en == 1'b0 && en_n == 1'b0)
      check($sformatf("ab_stable@%0d", cyc), {6'd0, a, b}, {6'd0, prev_ab});
    prev_en = en_n;
    prev_ab = {a, b};
    cyc++;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    cycle();
    stop = 1'b0;
  endtask

  initial begin
    int n, g;
    bit found, wrap_seen;

    // 1: reset with random inputs
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start   = 1'($urandom_range(0, 1));
      stop    = 1'($urandom_range(0, 1));
      dwell   = 8'($urandom_range(0, 255));
      ch_mask = 4'($urandom_range(0, 15));
      cycle();
    end
    check("reset_vals", {3'd0, en_n, a, b, busy, wrap}, 8'b0001_0000);
    rst = 1'b0; start = 1'b0; stop = 1'b0;
    cycle();

    // 2: full scan
    ch_mask = 4'b1111; dwell = 8'd2;
    start = 1'b1; cycle(); start = 1'b0;
    check("full_first", {4'd0, en_n, a, b, busy}, 8'b0000_1001);
    for (int i = 0; i < 40; i++) cycle();
    do_stop();

    // 3: sparse mask
    ch_mask = 4'b1010; dwell = 8'd0;
    start = 1'b1; cycle(); start = 1'b0;
    check("sparse_first", {6'd0, a, b}, 8'd1);
    for (int i = 0; i < 16; i++) cycle();
    do_stop();

    // 4: stop mid-DWELL on channel 2, then stop beats start
    ch_mask = 4'b1111; dwell = 8'd3;
    start = 1'b1; cycle(); start = 1'b0;
    found = 0;
    for (g = 0; g < 50 && !found; g++) begin
      cycle();
      if (en_n == 1'b0 && {a, b} == 2'd2) found = 1;
    end
    check("wait_ch2", {7'd0, found}, 8'd1);
    do_stop();
    check("stop_en_n", {7'd0, en_n}, 8'd1);
    check("stop_busy", {7'd0, busy}, 8'd0);
    check("stop_ab", {6'd0, a, b}, 8'd2);
    start = 1'b1; stop = 1'b1; cycle();
    check("stop_prio", {7'd0, busy}, 8'd0);
    start = 1'b0; stop = 1'b0;
    cycle();

    // 5: dwell change mid-DWELL, then mask cleared
    ch_mask = 4'b1111; dwell = 8'd2;
    start = 1'b1; cycle(); start = 1'b0;
    g = 0;
    while (en_n && g < 20) begin cycle(); g++; end
    dwell = 8'd5;
    n = 0;
    while (!en_n && g < 40) begin n++; cycle(); g++; end
    check("dwell_cur", 8'(n), 8'd3);
    while (en_n && g < 60) begin cycle(); g++; end
    n = 0;
    while (!en_n && g < 80) begin n++; cycle(); g++; end
    check("dwell_next", 8'(n), 8'd6);
    while (en_n && g < 100) begin cycle(); g++; end
    ch_mask = 4'd0;
    wrap_seen = 0;
    while (busy && g < 120) begin cycle(); g++; if (wrap) wrap_seen = 1; end
    check("mask0_idle", {7'd0, busy}, 8'd0);
    check("mask0_en_n", {7'd0, en_n}, 8'd1);
    check("mask0_nowrap", {7'd0, wrap_seen}, 8'd0);
    cycle();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 99) == 0);
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      dwell = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) ch_mask = 4'($urandom_range(0, 15));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
